// File: rtl/fifo_poll_scheduler.sv
// Round-robin read scheduler for per-channel DCFIFOs; emits one header word plus BURST data words per grant.
// Latency: grant one cycle after an eligible channel is seen in IDLE; one data word per cycle while streaming.
// Backpressure: up_ready low stalls a 2-entry skid buffer; rdreq is withheld in the same cycle so occupancy+inflight <= 2.
module fifo_poll_scheduler #(
    parameter int          NCH    = 4,
    parameter int          DW     = 64,
    parameter int          UW     = 13,
    parameter int          BURST  = 16,
    parameter int          RD_LAT = 1,
    parameter logic [15:0] SYNC   = 16'hEB90
) (
    input  logic               rdclk,
    input  logic               rst,
    input  logic [NCH*UW-1:0]  rdusedw,
    input  logic [NCH*DW-1:0]  q,
    output logic [NCH-1:0]     rdreq,
    input  logic               up_ready,
    output logic               data_valid,
    output logic [DW-1:0]      up_data,
    output logic               up_sof,
    output logic               up_eof,
    output logic [2:0]         up_ch
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // The capture path assumes q is valid exactly one cycle after rdreq.
    if (RD_LAT != 1) begin : g_lat_check
        $error("fifo_poll_scheduler supports RD_LAT == 1 only");
    end

    typedef enum logic [1:0] {IDLE, HDR, READ, DONE} state_t;

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic [2:0]    ch;
        logic [DW-1:0] dat;
    } word_t;

    state_t            state;
    logic [NCH*UW-1:0] usedw_q;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     grant_ch;
    logic [CW-1:0]     pick;
    logic              found;
    logic [7:0]        words_left;
    logic [31:0]       seq [NCH];
    int                idx;

    // Skid buffer: ent0 is the registered output word, ent1 the overflow slot.
    word_t             ent0;
    word_t             ent1;
    word_t             push_word;
    logic [1:0]        occ;
    logic              pend;
    logic              pop;
    logic              push;
    logic              hdr_push;
    logic              rd_go;
    logic [2:0]        fill;

    assign pop  = (occ != 2'd0) && up_ready;
    // Words the skid will hold after this edge, before any new rdreq lands.
    assign fill = 3'(occ) - 3'(pop) + 3'(pend);

    assign hdr_push = (state == HDR) && (fill < 3'd2);
    assign rd_go    = (state == READ) && (words_left != 8'd0) && (fill < 3'd2);
    assign rdreq    = rd_go ? (NCH'(1) << grant_ch) : '0;
    assign push     = pend || hdr_push;

    assign data_valid = (occ != 2'd0);
    assign up_data    = ent0.dat;
    assign up_sof     = ent0.sof;
    assign up_eof     = ent0.eof;
    assign up_ch      = ent0.ch;

    // Rotating priority search from rr_ptr for the first channel holding a full burst.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && (usedw_q[idx*UW +: UW] >= UW'(BURST))) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    // Word entering the skid: captured FIFO data takes the slot, otherwise the header.
    always_comb begin
        push_word = '0;
        if (pend) begin
            push_word.sof = 1'b0;
            push_word.eof = (words_left == 8'd0);
            push_word.ch  = 3'(grant_ch);
            push_word.dat = q[grant_ch*DW +: DW];
        end else begin
            push_word.sof = 1'b1;
            push_word.eof = 1'b0;
            push_word.ch  = 3'(grant_ch);
            push_word.dat = DW'({SYNC, 5'b0, 3'(grant_ch), 8'(BURST), seq[grant_ch]});
        end
    end

    // Register rdusedw so the eligibility compare sees a clean, clock-aligned level.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) usedw_q <= '0;
        else     usedw_q <= rdusedw;
    end

    // Two-entry skid buffer with simultaneous push/pop; ent0 only changes on pop or push into empty.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else if (push && pop) begin
            if (occ == 2'd1) begin
                ent0 <= push_word;
            end else begin
                ent0 <= ent1;
                ent1 <= push_word;
            end
        end else if (pop) begin
            ent0 <= ent1;
            occ  <= occ - 2'd1;
        end else if (push) begin
            if (occ == 2'd0) ent0 <= push_word;
            else             ent1 <= push_word;
            occ <= occ + 2'd1;
        end
    end

    // Frame sequencer: grant, header, burst read, then drain and advance the round-robin pointer.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_ch   <= '0;
            words_left <= 8'd0;
            pend       <= 1'b0;
            for (int c = 0; c < NCH; c++) seq[c] <= 32'd0;
        end else begin
            pend <= rd_go;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_ch   <= pick;
                        words_left <= 8'(BURST);
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_push) state <= READ;
                end
                READ: begin
                    if (rd_go) words_left <= words_left - 8'd1;
                    if ((words_left == 8'd0) && !pend) state <= DONE;
                end
                DONE: begin
                    if (occ == 2'd0) begin
                        seq[grant_ch] <= seq[grant_ch] + 32'd1;
                        rr_ptr        <= (int'(grant_ch) == NCH - 1) ? '0 : grant_ch + CW'(1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_poll_scheduler.sv
`timescale 1ns/1ps
module tb_fifo_poll_scheduler;

    localparam int NCH   = 4;
    localparam int DW    = 64;
    localparam int UW    = 13;
    localparam int BURST = 16;

    logic              rdclk = 1'b0;
    logic              rst   = 1'b1;
    logic [NCH*UW-1:0] rdusedw;
    logic [NCH*DW-1:0] q = '0;
    logic [NCH-1:0]    rdreq;
    logic              up_ready;
    logic              data_valid;
    logic [DW-1:0]     up_data;
    logic              up_sof;
    logic              up_eof;
    logic [2:0]        up_ch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 rdclk = ~rdclk;

    fifo_poll_scheduler #(
        .NCH(NCH), .DW(DW), .UW(UW), .BURST(BURST), .RD_LAT(1), .SYNC(16'hEB90)
    ) dut (
        .rdclk(rdclk), .rst(rst), .rdusedw(rdusedw), .q(q), .rdreq(rdreq),
        .up_ready(up_ready), .data_valid(data_valid), .up_data(up_data),
        .up_sof(up_sof), .up_eof(up_eof), .up_ch(up_ch)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data pattern produced by the FIFO model: channel in top byte, read index in low word.
    function automatic logic [63:0] wd(input int c, input int n);
        return {8'hD0 + 8'(c), 24'h0, 32'(n)};
    endfunction

    // FIFO model: normal-mode DCFIFO, q updates one edge after rdreq.
    int rd_cnt [NCH] = '{default: 0};
    always @(posedge rdclk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rdreq[c]) begin
                q[c*DW +: DW] <= wd(c, rd_cnt[c]);
                rd_cnt[c]     <= rd_cnt[c] + 1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [63:0] mq_dat [$];
    logic        mq_sof [$];
    logic        mq_eof [$];
    logic [2:0]  mq_ch  [$];
    int          rdreq_cnt [NCH] = '{default: 0};
    int          exp_idx   [NCH] = '{default: 0};
    int          outst = 0, max_outst = 0, multi_err = 0, stab_err = 0;
    logic        held = 1'b0;
    logic [63:0] held_dat;
    logic        held_sof, held_eof;
    logic [2:0]  held_ch;
    logic        tog_en = 1'b0;

    always @(negedge rdclk) begin
        if (rst) begin
            held  = 1'b0;
            outst = 0;
        end else begin
            if (held && (!data_valid || up_data !== held_dat || up_sof !== held_sof ||
                         up_eof !== held_eof || up_ch !== held_ch))
                stab_err++;
            for (int c = 0; c < NCH; c++) if (rdreq[c]) rdreq_cnt[c]++;
            if ($countones(rdreq) > 1) multi_err++;
            if (rdreq != '0) outst++;
            if (data_valid && up_ready) begin
                mq_dat.push_back(up_data);
                mq_sof.push_back(up_sof);
                mq_eof.push_back(up_eof);
                mq_ch.push_back(up_ch);
                if (!up_sof) outst--;
            end
            if (outst > max_outst) max_outst = outst;
            held     = data_valid && !up_ready;
            held_dat = up_data;
            held_sof = up_sof;
            held_eof = up_eof;
            held_ch  = up_ch;
        end
    end

    task automatic set_used(input int c, input int v);
        rdusedw[c*UW +: UW] = UW'(v);
    endtask

    task automatic flush_mon();
        mq_dat.delete();
        mq_sof.delete();
        mq_eof.delete();
        mq_ch.delete();
        for (int c = 0; c < NCH; c++) begin
            rdreq_cnt[c] = 0;
            exp_idx[c]   = rd_cnt[c];
        end
    endtask

    task automatic do_reset();
        @(posedge rdclk); #1;
        rst = 1'b1;
        repeat (2) @(posedge rdclk);
        #1;
        rst = 1'b0;
        flush_mon();
    endtask

    task automatic get_word(output logic [63:0] d, output logic s, output logic e,
                            output logic [2:0] ch);
        int t;
        t = 0;
        while (mq_dat.size() == 0 && t < 3000) begin
            @(negedge rdclk);
            t++;
        end
        if (mq_dat.size() == 0) begin
            chk("word_timeout", 64'(mq_dat.size()), 64'd1);
            d = '0; s = 1'b0; e = 1'b0; ch = 3'd0;
        end else begin
            d  = mq_dat.pop_front();
            s  = mq_sof.pop_front();
            e  = mq_eof.pop_front();
            ch = mq_ch.pop_front();
        end
    endtask

    // Checks one complete frame; optionally clears all rdusedw once the header is seen.
    task automatic chk_frame(input int ch, input logic [31:0] seq, input string nm, input bit stop);
        logic [63:0] d;
        logic        s, e;
        logic [2:0]  c;
        get_word(d, s, e, c);
        if (stop) rdusedw = '0;
        chk({nm, "_hdr"}, d, {16'hEB90, 5'b0, 3'(ch), 8'(BURST), seq});
        chk({nm, "_sof"}, 64'(s), 64'd1);
        chk({nm, "_ch"},  64'(c), 64'(ch));
        for (int i = 0; i < BURST; i++) begin
            get_word(d, s, e, c);
            chk({nm, "_dat"}, d, wd(ch, exp_idx[ch]));
            exp_idx[ch]++;
            chk({nm, "_eof"}, 64'(e), 64'(i == BURST - 1));
            chk({nm, "_dsof"}, 64'(s), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic        s, e;
        logic [2:0]  c;

        rdusedw  = '0;
        up_ready = 1'b1;
        rst      = 1'b1;
        repeat (3) @(posedge rdclk);
        #1;
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_rdreq", 64'(rdreq), 64'd0);
        chk("rst_data",  up_data, 64'd0);
        chk("rst_flags", {61'd0, up_sof, up_eof, 1'b0}, 64'd0);
        chk("rst_ch",    64'(up_ch), 64'd0);
        rst = 1'b0;
        flush_mon();

        // No channel eligible: nothing must move.
        repeat (100) @(posedge rdclk);
        #1;
        chk("idle_rdreq", 64'(rdreq_cnt[0] + rdreq_cnt[1] + rdreq_cnt[2] + rdreq_cnt[3]), 64'd0);
        chk("idle_words", 64'(mq_dat.size()), 64'd0);

        // Single channel 2: two back-to-back frames, seq 0 then 1.
        set_used(2, 20);
        chk_frame(2, 32'd0, "ch2_f0", 1'b0);
        chk("ch2_rdreq", 64'(rdreq_cnt[2]), 64'd16);
        chk_frame(2, 32'd1, "ch2_f1", 1'b1);
        repeat (30) @(posedge rdclk);

        // All channels eligible: strict round-robin from channel 0.
        do_reset();
        for (int k = 0; k < NCH; k++) set_used(k, 4000);
        chk_frame(0, 32'd0, "rr0", 1'b0);
        chk_frame(1, 32'd0, "rr1", 1'b0);
        chk_frame(2, 32'd0, "rr2", 1'b0);
        chk_frame(3, 32'd0, "rr3", 1'b0);
        chk_frame(0, 32'd1, "rr0b", 1'b1);
        repeat (30) @(posedge rdclk);

        // Channel 1 with up_ready toggling every cycle.
        do_reset();
        max_outst = 0;
        set_used(1, 16);
        tog_en = 1'b1;
        fork
            begin
                while (tog_en) begin
                    @(posedge rdclk); #1;
                    up_ready = ~up_ready;
                end
                up_ready = 1'b1;
            end
        join_none
        chk_frame(1, 32'd0, "tog", 1'b1);
        tog_en = 1'b0;
        repeat (30) @(posedge rdclk);
        chk("tog_outst", 64'(max_outst <= 2), 64'd1);
        chk("tog_rdreq", 64'(rdreq_cnt[1]), 64'd16);

        // Channel 3 frame interrupted by reset during its 8th data word.
        set_used(3, 20);
        get_word(d, s, e, c);
        chk("cut_hdr", d, 64'hEB90_0310_0000_0000);
        for (int i = 0; i < 7; i++) get_word(d, s, e, c);
        @(negedge rdclk);
        rst = 1'b1;
        #1;
        chk("cut_valid", 64'(data_valid), 64'd0);
        chk("cut_rdreq", 64'(rdreq), 64'd0);
        chk("cut_data",  up_data, 64'd0);
        chk("cut_flags", {62'd0, up_sof, up_eof}, 64'd0);
        chk("cut_ch",    64'(up_ch), 64'd0);
        @(posedge rdclk); #1;
        chk("cut_valid_edge", 64'(data_valid), 64'd0);
        @(posedge rdclk); #1;
        rst = 1'b0;
        flush_mon();
        // rr_ptr back at 0 picks channel 1 before 3; channel 1's seq was cleared.
        set_used(1, 16);
        chk_frame(1, 32'd0, "post1", 1'b0);
        chk_frame(3, 32'd0, "post3", 1'b1);
        repeat (30) @(posedge rdclk);

        // Channel 0 one word short of a burst must never be granted.
        do_reset();
        set_used(0, BURST - 1);
        set_used(1, BURST);
        chk_frame(1, 32'd0, "short", 1'b1);
        set_used(0, BURST - 1);
        repeat (100) @(posedge rdclk);
        #1;
        chk("short_rdreq0", 64'(rdreq_cnt[0]), 64'd0);
        chk("short_words", 64'(mq_dat.size()), 64'd0);

        chk("stable_hold", 64'(stab_err), 64'd0);
        chk("onehot_rdreq", 64'(multi_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
